// File: rtl/hex_display_hold.sv
// N-digit hex seven-segment driver with a retriggerable hold timer, optional
// leading-zero blanking and a time-multiplexed common-anode scan output.
module hex_display_hold #(
   parameter int unsigned NDIGITS     = 2,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned HOLD_CYCLES = 32'h9fffff,
   parameter int unsigned SCAN_DIV    = 1024,
   parameter bit          LZ_BLANK    = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ready,
   input  logic                 clear,
   input  logic [4*NDIGITS-1:0] in,
   output logic [7*NDIGITS-1:0] out,
   output logic [6:0]           scan_seg,
   output logic [NDIGITS-1:0]   scan_an,
   output logic                 active
);

   localparam int unsigned DW    = 4 * NDIGITS;
   localparam int unsigned SW    = 7 * NDIGITS;
   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   logic [DW-1:0]      data_q;
   logic [CNT_W-1:0]   cnt;
   logic [DIV_W-1:0]   div;
   logic [IDX_W-1:0]   idx;
   logic [SW-1:0]      seg_all;
   logic               upper_zero;
   logic [6:0]         scan_pick;
   logic [NDIGITS-1:0] an_pick;

   function automatic logic [6:0] hex7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign active = (cnt != '0);

   // Capture and hold timer: clear beats ready beats decrement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         cnt    <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (ready) begin
         data_q <= in;
         cnt    <= CNT_W'(HOLD_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Walk from the top digit down; a digit is blanked while all digits at and above it are zero.
   always_comb begin
      seg_all    = '1;
      upper_zero = 1'b1;
      for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (data_q[4*i +: 4] == 4'h0);
         if (LZ_BLANK && (i != 0) && upper_zero)
            seg_all[7*i +: 7] = 7'h7F;
         else
            seg_all[7*i +: 7] = hex7(data_q[4*i +: 4]);
      end
   end

   always_comb begin
      scan_pick = 7'h7F;
      an_pick   = '1;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         if (idx == IDX_W'(i)) begin
            scan_pick  = seg_all[7*i +: 7];
            an_pick[i] = 1'b0;
         end
      end
   end

   // Free-running scan slot divider and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
         idx <= '0;
      end else if (div == DIV_W'(SCAN_DIV - 1)) begin
         div <= '0;
         idx <= (idx == IDX_W'(NDIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out      <= '1;
         scan_seg <= 7'h7F;
         scan_an  <= '1;
      end else begin
         out      <= active ? seg_all   : '1;
         scan_seg <= active ? scan_pick : 7'h7F;
         scan_an  <= active ? an_pick   : '1;
      end
   end

endmodule

// File: tb/tb_hex_display_hold.sv
// Bench for hex_display_hold: two configurations driven by directed and random
// capture/clear traffic, compared against a value/remaining-time display model.
module tb_hex_display_hold;

   logic clk = 1'b0;
   logic rst;
   logic readyA, clearA, readyB, clearB;
   logic [7:0]  inA;
   logic [15:0] inB;
   logic [13:0] outA;
   logic [27:0] outB;
   logic [6:0]  segA, segB;
   logic [1:0]  anA;
   logic [3:0]  anB;
   logic        actA, actB;

   hex_display_hold #(.NDIGITS(2), .CNT_W(32), .HOLD_CYCLES(5), .SCAN_DIV(4), .LZ_BLANK(1'b0)) dut_a (
      .clk(clk), .rst(rst), .ready(readyA), .clear(clearA), .in(inA),
      .out(outA), .scan_seg(segA), .scan_an(anA), .active(actA));

   hex_display_hold #(.NDIGITS(4), .CNT_W(8), .HOLD_CYCLES(7), .SCAN_DIV(3), .LZ_BLANK(1'b1)) dut_b (
      .clk(clk), .rst(rst), .ready(readyB), .clear(clearB), .in(inB),
      .out(outB), .scan_seg(segB), .scan_an(anB), .active(actB));

   always #5 clk = ~clk;

   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          nd [2] = '{2, 4};
   bit          lz [2] = '{1'b0, 1'b1};
   int unsigned hc [2] = '{5, 7};
   int          sd [2] = '{4, 3};

   int unsigned mval [2];
   int unsigned mhold [2];
   int          edges;
   logic [63:0] exp_out [2];
   logic [63:0] exp_seg [2];
   logic [63:0] exp_an  [2];

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Digits of v as they should appear, with optional leading-zero blanking.
   function automatic logic [63:0] disp(input int k, input int unsigned v);
      logic [63:0] r = '0;
      for (int i = 0; i < nd[k]; i++) begin
         if (lz[k] && i > 0 && (v >> (4*i)) == 0) r[7*i +: 7] = 7'h7F;
         else r[7*i +: 7] = SEG[(v >> (4*i)) & 15];
      end
      return r;
   endfunction

   task automatic check_all();
      chk("A_out", 64'(outA), exp_out[0]);
      chk("A_scan_seg", 64'(segA), exp_seg[0]);
      chk("A_scan_an", 64'(anA), exp_an[0]);
      chk("A_active", 64'(actA), 64'(mhold[0] != 0));
      chk("B_out", 64'(outB), exp_out[1]);
      chk("B_scan_seg", 64'(segB), exp_seg[1]);
      chk("B_scan_an", 64'(anB), exp_an[1]);
      chk("B_active", 64'(actB), 64'(mhold[1] != 0));
   endtask

   task automatic step(input bit ra, input bit ca, input logic [7:0] ia,
                       input bit rb, input bit cb, input logic [15:0] ib);
      bit r [2];
      bit c [2];
      int unsigned v [2];
      int idx;
      r[0] = ra; c[0] = ca; v[0] = 32'(ia);
      r[1] = rb; c[1] = cb; v[1] = 32'(ib);
      @(negedge clk);
      readyA = ra; clearA = ca; inA = ia;
      readyB = rb; clearB = cb; inB = ib;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         idx = (edges / sd[k]) % nd[k];
         if (mhold[k] != 0) begin
            exp_out[k] = disp(k, mval[k]);
            exp_seg[k] = (exp_out[k] >> (7*idx)) & 64'h7F;
            exp_an[k]  = ((64'd1 << nd[k]) - 1) & ~(64'd1 << idx);
         end else begin
            exp_out[k] = (64'd1 << (7*nd[k])) - 1;
            exp_seg[k] = 64'h7F;
            exp_an[k]  = (64'd1 << nd[k]) - 1;
         end
         if (c[k]) mhold[k] = 0;
         else if (r[k]) begin mval[k] = v[k]; mhold[k] = hc[k]; end
         else if (mhold[k] != 0) mhold[k]--;
      end
      edges++;
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, inA, 1'b0, 1'b0, inB);
   endtask

   task automatic reset_checks();
      chk("R_A_out", 64'(outA), 64'h3FFF);
      chk("R_A_seg", 64'(segA), 64'h7F);
      chk("R_A_an", 64'(anA), 64'h3);
      chk("R_A_act", 64'(actA), 64'h0);
      chk("R_B_out", 64'(outB), 64'hFFFFFFF);
      chk("R_B_an", 64'(anB), 64'hF);
      chk("R_B_act", 64'(actB), 64'h0);
   endtask

   initial begin
      rst = 1'b0;
      readyA = 1'b0; clearA = 1'b0; inA = '0;
      readyB = 1'b0; clearB = 1'b0; inB = '0;
      mval = '{0, 0}; mhold = '{0, 0}; edges = 0;
      #1 rst = 1'b1;
      #2 reset_checks();
      @(posedge clk);
      #2 rst = 1'b0;

      // Basic capture and expiry
      step(1'b1, 1'b0, 8'h3A, 1'b1, 1'b0, 16'h0005);
      idle(1);
      chk("A_3A_enc", 64'(outA), 64'h1808);
      chk("B_lz_0005", 64'(outB), 64'hFFFFF92);
      idle(8);
      chk("A_expired", 64'(outA), 64'h3FFF);

      // Retrigger partway through a hold
      step(1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 16'h0000);
      idle(3);
      chk("B_lz_zero", 64'(outB), 64'hFFFFFC0);
      step(1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 16'h0000);
      idle(1);
      chk("A_F0_enc", 64'(outA), 64'h0740);
      idle(6);

      // clear beats ready; data kept for a later redisplay
      step(1'b1, 1'b0, 8'hC4, 1'b1, 1'b0, 16'hA0B0);
      idle(2);
      step(1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 16'h1234);
      idle(1);
      chk("A_clear_blank", 64'(outA), 64'h3FFF);
      chk("A_clear_act", 64'(actA), 64'h0);
      step(1'b1, 1'b0, 8'hC4, 1'b1, 1'b0, 16'hA0B0);
      idle(12);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, 8'($urandom),
              $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0, 16'($urandom));
      end
      idle(10);

      // Asynchronous reset in the middle of a hold
      step(1'b1, 1'b0, 8'h5E, 1'b1, 1'b0, 16'h0700);
      idle(2);
      #2 rst = 1'b1;
      #1 reset_checks();
      @(posedge clk);
      #2 rst = 1'b0;
      mval = '{0, 0}; mhold = '{0, 0}; edges = 0;
      idle(6);
      chk("post_reset_A", 64'(outA), 64'h3FFF);
      step(1'b1, 1'b0, 8'h5E, 1'b1, 1'b0, 16'h0700);
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
